rv_imem_line_buffer: RTL and testbench



---
 rtl/rv_imem_line_buffer.sv | 138 +++++++++++++
 tb/tb_rv_imem_line_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rv_imem_line_buffer.sv
// Single-line instruction buffer on the core's fetch port.
// Lookups hit in one cycle; a miss refills the whole line over a req/ack bus.
module rv_imem_line_buffer #(
   parameter int LINE_WORDS = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   input  logic        inv_i,
   output logic [31:0] m_adr_o,
   output logic        m_stb_o,
   input  logic        m_ack_i,
   input  logic [31:0] m_dat_i
);

   localparam int LW_BITS  = $clog2(LINE_WORDS);
   localparam int TAG_BITS = 30 - LW_BITS;
   localparam logic [LW_BITS-1:0] CNT_ONE  = LW_BITS'(1);
   localparam logic [LW_BITS-1:0] CNT_LAST = LW_BITS'(LINE_WORDS - 1);

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           line_q [LINE_WORDS];
   logic [31:0]           line_d [LINE_WORDS];
   logic [TAG_BITS-1:0]   tag_q, tag_d;
   logic                  line_valid_q, line_valid_d;
   logic [LW_BITS-1:0]    cnt_q, cnt_d;
   logic                  inv_pending_q, inv_pending_d;
   logic                  im_valid_q, im_valid_d;
   logic [31:0]           im_data_q, im_data_d;
   logic                  stb_q, stb_d;
   logic [31:0]           adr_q, adr_d;

   logic [TAG_BITS-1:0]   req_tag;
   logic [LW_BITS-1:0]    req_idx;
   logic [LW_BITS-1:0]    cnt_inc;
   logic                  hit;

   assign req_tag = im_addr_i[31:2+LW_BITS];
   assign req_idx = im_addr_i[1+LW_BITS:2];
   assign cnt_inc = cnt_q + CNT_ONE;
   assign hit     = line_valid_q && (req_tag == tag_q) && !inv_i;

   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      tag_d         = tag_q;
      line_valid_d  = line_valid_q;
      cnt_d         = cnt_q;
      inv_pending_d = inv_pending_q;
      im_valid_d    = 1'b0;
      im_data_d     = im_data_q;
      stb_d         = stb_q;
      adr_d         = adr_q;

      unique case (state_q)
         IDLE: begin
            if (hit) begin
               im_valid_d = 1'b1;
               im_data_d  = line_q[req_idx];
            end else begin
               // An invalidate only drops the line; the next lookup refetches.
               line_valid_d = 1'b0;
               tag_d        = req_tag;
               if (!inv_i) begin
                  state_d = FILL;
                  stb_d   = 1'b1;
                  adr_d   = {req_tag, {LW_BITS{1'b0}}, 2'b00};
                  cnt_d   = '0;
               end
            end
         end

         FILL: begin
            if (inv_i) begin
               inv_pending_d = 1'b1;
            end
            if (m_ack_i) begin
               line_d[cnt_q] = m_dat_i;
               cnt_d         = cnt_inc;
               adr_d         = {adr_q[31:2+LW_BITS], cnt_inc, 2'b00};
               if (cnt_q == CNT_LAST) begin
                  // A fill invalidated in flight still completes but is discarded.
                  state_d       = IDLE;
                  stb_d         = 1'b0;
                  line_valid_d  = !(inv_pending_q || inv_i);
                  inv_pending_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         tag_q         <= '0;
         line_valid_q  <= 1'b0;
         cnt_q         <= '0;
         inv_pending_q <= 1'b0;
         im_valid_q    <= 1'b0;
         im_data_q     <= '0;
         stb_q         <= 1'b0;
         adr_q         <= '0;
      end else begin
         state_q       <= state_d;
         tag_q         <= tag_d;
         line_valid_q  <= line_valid_d;
         cnt_q         <= cnt_d;
         inv_pending_q <= inv_pending_d;
         im_valid_q    <= im_valid_d;
         im_data_q     <= im_data_d;
         stb_q         <= stb_d;
         adr_q         <= adr_d;
      end
   end

   // Line storage needs no reset; line_valid_q guards it.
   always_ff @(posedge clk_i) begin
      line_q <= line_d;
   end

   assign im_data_o  = im_data_q;
   assign im_valid_o = im_valid_q;
   assign m_adr_o    = adr_q;
   assign m_stb_o    = stb_q;

endmodule

// File: tb/tb_rv_imem_line_buffer.sv
// Directed bench for rv_imem_line_buffer with a wait-state backend model
// and a queue of expected fetch data.
module tb_rv_imem_line_buffer;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] im_addr_i;
   logic [31:0] im_data_o;
   logic        im_valid_o;
   logic        inv_i;
   logic [31:0] m_adr_o;
   logic        m_stb_o;
   logic        m_ack_i;
   logic [31:0] m_dat_i;

   int          checkCount = 0;
   int          passCount  = 0;
   int          waitStates = 0;
   int          waitCnt    = 0;
   int          beatSerial = 1;
   logic [31:0] expQ [$];
   logic [31:0] busLog [$];
   logic [31:0] lastServed [1024];

   rv_imem_line_buffer #(.LINE_WORDS(4)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .im_addr_i  (im_addr_i),
      .im_data_o  (im_data_o),
      .im_valid_o (im_valid_o),
      .inv_i      (inv_i),
      .m_adr_o    (m_adr_o),
      .m_stb_o    (m_stb_o),
      .m_ack_i    (m_ack_i),
      .m_dat_i    (m_dat_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Low line holds the fixed 0x11..0x44 pattern; elsewhere each beat is unique.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      logic [31:0] idx;
      idx = {30'b0, a[3:2]} + 32'd1;
      if (a < 32'h10) return 32'h11 * idx;
      return {beatSerial[15:0], a[15:0]};
   endfunction

   initial begin
      m_ack_i = 1'b0;
      m_dat_i = '0;
      forever begin
         @(posedge clk_i);
         #2;
         m_ack_i = 1'b0;
         if (rst_i) begin
            waitCnt = 0;
         end else if (m_stb_o === 1'b1) begin
            if (waitCnt < waitStates) begin
               waitCnt++;
            end else begin
               waitCnt = 0;
               m_dat_i = memWord(m_adr_o);
               lastServed[m_adr_o[11:2]] = m_dat_i;
               busLog.push_back(m_adr_o);
               m_ack_i = 1'b1;
               beatSerial++;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input bit expectHit, input logic [31:0] expData);
      im_addr_i = addr;
      if (expectHit) expQ.push_back(expData);
   endtask

   task automatic checkFetch(input string tag);
      checkOutput({tag, "_valid"}, {31'b0, im_valid_o}, 32'd1);
      if (expQ.size() > 0) checkOutput({tag, "_data"}, im_data_o, expQ.pop_front());
      else checkOutput({tag, "_sb_empty"}, expQ.size(), 32'd1);
   endtask

   task automatic checkBusLine(input string tag, input logic [31:0] base);
      for (int i = 0; i < 4; i++) begin
         if (busLog.size() > 0) checkOutput(tag, busLog.pop_front(), base + 32'(4 * i));
         else checkOutput({tag, "_missing"}, busLog.size(), 32'd1);
      end
   endtask

   // Drives addr, then counts cycles (and strobe cycles) until valid returns.
   task automatic runFill(input logic [31:0] addr, input int invAt, input int changeAt,
                          input logic [31:0] newAddr, output int cycles, output int stbCycles);
      cycles    = 0;
      stbCycles = 0;
      im_addr_i = addr;
      while (cycles < 200) begin
         @(posedge clk_i);
         #1;
         cycles++;
         if (m_stb_o === 1'b1) stbCycles++;
         inv_i = (cycles == invAt);
         if (cycles == changeAt) im_addr_i = newAddr;
         if (im_valid_o === 1'b1) break;
      end
      inv_i = 1'b0;
   endtask

   initial begin
      int cyc;
      int stb;
      rst_i     = 1'b1;
      inv_i     = 1'b0;
      im_addr_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_valid", {31'b0, im_valid_o}, 32'd0);
      checkOutput("rst_data", im_data_o, 32'd0);
      checkOutput("rst_stb", {31'b0, m_stb_o}, 32'd0);
      checkOutput("rst_adr", m_adr_o, 32'd0);
      rst_i = 1'b0;

      $display("[TB] first fill at 0x0");
      expQ.push_back(32'h11);
      runFill(32'h0, 0, 0, 32'h0, cyc, stb);
      checkOutput("fill0_latency", 32'(cyc), 32'd6);
      checkOutput("fill0_stb_cycles", 32'(stb), 32'd4);
      checkBusLine("fill0_adr", 32'h0);
      checkFetch("fill0");

      $display("[TB] back-to-back sweep");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'(4 * i), 1'b1, 32'h11 * 32'(i + 1));
         @(posedge clk_i);
         #1;
         checkFetch("sweep");
         checkOutput("sweep_stb", {31'b0, m_stb_o}, 32'd0);
      end

      $display("[TB] fill at 0x10 with wait states");
      waitStates = 3;
      runFill(32'h10, 0, 0, 32'h0, cyc, stb);
      waitStates = 0;
      checkOutput("wait_latency", 32'(cyc), 32'd18);
      checkOutput("wait_stb_cycles", 32'(stb), 32'd16);
      checkBusLine("wait_adr", 32'h10);
      expQ.push_back(lastServed[32'h10 >> 2]);
      checkFetch("wait");

      $display("[TB] invalidate during fill at 0x20");
      runFill(32'h20, 2, 0, 32'h0, cyc, stb);
      checkOutput("inv_latency", 32'(cyc), 32'd11);
      checkOutput("inv_stb_cycles", 32'(stb), 32'd8);
      checkBusLine("inv_adr_first", 32'h20);
      checkBusLine("inv_adr_refill", 32'h20);
      expQ.push_back(lastServed[32'h20 >> 2]);
      checkFetch("inv");

      $display("[TB] address change during fill 0x40 to 0x80");
      runFill(32'h40, 0, 2, 32'h80, cyc, stb);
      checkOutput("chg_latency", 32'(cyc), 32'd11);
      checkOutput("chg_stb_cycles", 32'(stb), 32'd8);
      checkBusLine("chg_adr_old", 32'h40);
      checkBusLine("chg_adr_new", 32'h80);
      expQ.push_back(lastServed[32'h80 >> 2]);
      checkFetch("chg");

      $display("[TB] reset during fill at 0xC0");
      im_addr_i = 32'hC0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("midrst_stb", {31'b0, m_stb_o}, 32'd0);
      checkOutput("midrst_valid", {31'b0, im_valid_o}, 32'd0);
      checkOutput("midrst_adr", m_adr_o, 32'd0);
      checkOutput("midrst_data", im_data_o, 32'd0);
      rst_i = 1'b0;
      busLog.delete();
      runFill(32'hC0, 0, 0, 32'h0, cyc, stb);
      checkOutput("postrst_latency", 32'(cyc), 32'd6);
      checkOutput("postrst_stb_cycles", 32'(stb), 32'd4);
      checkBusLine("postrst_adr", 32'hC0);
      expQ.push_back(lastServed[32'hC0 >> 2]);
      checkFetch("postrst");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
